stick_shot_ctrl: RTL and testbench

Shot sequencer for the cue stick. It aims the stick from the rotate keys, charges shot power while space is held, then animates the release. At the end of the release it issues a single strike command carrying the latched power and angle. It sits between the keyboard decoder and the stick drawing object / cue-ball physics, and all state advances on `startOfFrame` ticks.

---
 rtl/stick_pkg.sv | 16 +
 rtl/stick_angle_ctrl.sv | 42 ++++
 rtl/stick_shot_ctrl.sv | 161 ++++++++++++++++
 tb/tb_stick_shot_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stick_pkg.sv
// Shared types and constants for the cue stick shot sequencer.
package stick_pkg;

    localparam int ANGLE_W   = 10;
    localparam int POWER_W   = 7;
    localparam int MAX_ANGLE = 359;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_AIM      = 3'd1,
        ST_CHARGE   = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_COOLDOWN = 3'd4
    } stick_state_t;

endpackage

// File: rtl/stick_angle_ctrl.sv
// Registered aim angle: one +/- step per enabled cycle, wrapped modulo 360.
module stick_angle_ctrl
    import stick_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               rot_up,
    input  logic               rot_down,
    input  logic [ANGLE_W-1:0] step,
    output logic [ANGLE_W-1:0] angle
);

    localparam logic signed [ANGLE_W:0] FULL_TURN = (ANGLE_W+1)'(MAX_ANGLE + 1);

    logic signed [ANGLE_W:0] delta;
    logic signed [ANGLE_W:0] sum;
    logic signed [ANGLE_W:0] wrapped;

    // Step is always below a full turn, so a single add/subtract of 360 suffices.
    always_comb begin
        delta = '0;
        if (rot_up && !rot_down)
            delta = $signed({1'b0, step});
        else if (rot_down && !rot_up)
            delta = -$signed({1'b0, step});
        sum     = $signed({1'b0, angle}) + delta;
        wrapped = sum;
        if (sum[ANGLE_W])
            wrapped = sum + FULL_TURN;
        else if (sum >= FULL_TURN)
            wrapped = sum - FULL_TURN;
    end

    always_ff @(posedge clk) begin
        if (reset)
            angle <= '0;
        else if (en)
            angle <= wrapped[ANGLE_W-1:0];
    end

endmodule

// File: rtl/stick_shot_ctrl.sv
// Cue stick shot sequencer: aim, charge, release animation, single strike command.
// Optional STICK_FINE_AIM_EN adds a fine_aim input that drops the rotate step to 1 degree.
//
// state       | meaning
// IDLE        | stick hidden, waiting for game in play and balls at rest
// AIM         | rotate keys move the angle, space starts charging
// CHARGE      | pull_back grows while space is held
// RELEASE     | pull_back winds down, strike issued when it hits 0
// COOLDOWN    | waiting for balls to start moving after the strike
module stick_shot_ctrl
    import stick_pkg::*;
#(
    parameter int ANGLE_STEP      = 2,
    parameter int POWER_MAX       = 100,
    parameter int RELEASE_STEP    = 3,
    parameter int COOLDOWN_FRAMES = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               game_state,
    input  logic               no_moving_flag,
    input  logic               left_pressed,
    input  logic               right_pressed,
    input  logic               space_pressed,
`ifdef STICK_FINE_AIM_EN
    input  logic               fine_aim,
`endif
    output logic [ANGLE_W-1:0] angle,
    output logic [POWER_W-1:0] pull_back,
    output logic               stick_visible,
    output logic               strike,
    output logic [POWER_W-1:0] strike_power,
    output logic [ANGLE_W-1:0] strike_angle
);

    localparam logic [POWER_W:0]   POW_ONE   = (POWER_W+1)'(1);
    localparam logic [POWER_W:0]   POW_MAX8  = (POWER_W+1)'(POWER_MAX);
    localparam logic [POWER_W:0]   REL_STEP8 = (POWER_W+1)'(RELEASE_STEP);
    localparam logic [7:0]         CD_LOAD   = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [ANGLE_W-1:0] STEP_DEF  = ANGLE_W'(ANGLE_STEP);

    stick_state_t       state, state_nxt;
    logic [POWER_W:0]   pow_up, pow_down;
    logic [POWER_W-1:0] pull_back_nxt, strike_power_nxt;
    logic [ANGLE_W-1:0] strike_angle_nxt, step;
    logic [7:0]         cd_cnt, cd_nxt;
    logic               cd_tc, strike_nxt, angle_en;

`ifdef STICK_FINE_AIM_EN
    assign step = fine_aim ? ANGLE_W'(1) : STEP_DEF;
`else
    assign step = STEP_DEF;
`endif

    always_comb begin
        pow_up = {1'b0, pull_back} + POW_ONE;
        if (pow_up > POW_MAX8)
            pow_up = POW_MAX8;
        pow_down = ({1'b0, pull_back} > REL_STEP8) ? ({1'b0, pull_back} - REL_STEP8) : '0;
    end

    assign cd_tc = (cd_cnt == '0);

    stick_angle_ctrl u_angle (
        .clk      (clk),
        .reset    (reset),
        .en       (angle_en),
        .rot_up   (left_pressed),
        .rot_down (right_pressed),
        .step     (step),
        .angle    (angle)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (startOfFrame) begin
            if (!game_state)
                state_nxt = ST_IDLE;
            else begin
                case (state)
                    ST_IDLE:     if (no_moving_flag) state_nxt = ST_AIM;
                    ST_AIM:      if (!no_moving_flag) state_nxt = ST_IDLE;
                                 else if (space_pressed) state_nxt = ST_CHARGE;
                    ST_CHARGE:   if (!space_pressed) state_nxt = ST_RELEASE;
                    ST_RELEASE:  if (pow_down == '0) state_nxt = ST_COOLDOWN;
                    ST_COOLDOWN: if (!no_moving_flag) state_nxt = ST_IDLE;
                                 else if (cd_tc) state_nxt = ST_AIM;
                    default:     state_nxt = ST_IDLE;
                endcase
            end
        end
    end

    // Abort on game_state drop takes precedence over the terminal release frame.
    always_comb begin
        pull_back_nxt    = pull_back;
        strike_power_nxt = strike_power;
        strike_angle_nxt = strike_angle;
        strike_nxt       = 1'b0;
        cd_nxt           = cd_cnt;
        angle_en         = 1'b0;
        if (startOfFrame) begin
            if (!game_state)
                pull_back_nxt = '0;
            else begin
                case (state)
                    ST_AIM: begin
                        angle_en = no_moving_flag;
                        if (no_moving_flag && space_pressed)
                            pull_back_nxt = POWER_W'(1);
                    end
                    ST_CHARGE: begin
                        if (space_pressed)
                            pull_back_nxt = pow_up[POWER_W-1:0];
                        else begin
                            strike_power_nxt = pull_back;
                            strike_angle_nxt = angle;
                        end
                    end
                    ST_RELEASE: begin
                        pull_back_nxt = pow_down[POWER_W-1:0];
                        if (pow_down == '0) begin
                            strike_nxt = 1'b1;
                            cd_nxt     = CD_LOAD;
                        end
                    end
                    ST_COOLDOWN: if (!cd_tc) cd_nxt = cd_cnt - 8'd1;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pull_back     <= '0;
            strike_power  <= '0;
            strike_angle  <= '0;
            strike        <= 1'b0;
            stick_visible <= 1'b0;
            cd_cnt        <= '0;
        end else begin
            pull_back     <= pull_back_nxt;
            strike_power  <= strike_power_nxt;
            strike_angle  <= strike_angle_nxt;
            strike        <= strike_nxt;
            stick_visible <= (state_nxt == ST_AIM) || (state_nxt == ST_CHARGE) ||
                             (state_nxt == ST_RELEASE);
            cd_cnt        <= cd_nxt;
        end
    end

endmodule

// File: tb/tb_stick_shot_ctrl.sv
// Bench for stick_shot_ctrl: directed scenarios plus randomized frames against a frame-level model.
module tb_stick_shot_ctrl;

    localparam int ANGLE_STEP      = 2;
    localparam int POWER_MAX       = 100;
    localparam int RELEASE_STEP    = 3;
    localparam int COOLDOWN_FRAMES = 8;
    localparam int S_IDLE = 0, S_AIM = 1, S_CHARGE = 2, S_RELEASE = 3, S_COOL = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startOfFrame = 1'b0;
    logic game_state = 1'b0;
    logic no_moving_flag = 1'b0;
    logic left_pressed = 1'b0;
    logic right_pressed = 1'b0;
    logic space_pressed = 1'b0;
`ifdef STICK_FINE_AIM_EN
    logic fine_aim = 1'b0;
`endif
    logic [9:0] angle;
    logic [6:0] pull_back;
    logic       stick_visible;
    logic       strike;
    logic [6:0] strike_power;
    logic [9:0] strike_angle;

    int total = 0;
    int bad = 0;
    int m_state, m_angle, m_pow, m_sp, m_sa, m_cool;
    bit m_strike;
    logic obs_strike, obs_strike_late;

    stick_shot_ctrl #(
        .ANGLE_STEP(ANGLE_STEP), .POWER_MAX(POWER_MAX),
        .RELEASE_STEP(RELEASE_STEP), .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .game_state(game_state),
        .no_moving_flag(no_moving_flag), .left_pressed(left_pressed),
        .right_pressed(right_pressed), .space_pressed(space_pressed),
`ifdef STICK_FINE_AIM_EN
        .fine_aim(fine_aim),
`endif
        .angle(angle), .pull_back(pull_back), .stick_visible(stick_visible),
        .strike(strike), .strike_power(strike_power), .strike_angle(strike_angle)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = S_IDLE; m_angle = 0; m_pow = 0; m_sp = 0; m_sa = 0; m_cool = 0; m_strike = 0;
    endtask

    // One frame of the shot rules, evaluated on the inputs present at the tick.
    task automatic model_tick();
        int stp;
        m_strike = 0;
        if (!game_state) begin
            m_state = S_IDLE;
            m_pow = 0;
            return;
        end
        case (m_state)
            S_IDLE: if (no_moving_flag) m_state = S_AIM;
            S_AIM: begin
                if (!no_moving_flag) m_state = S_IDLE;
                else begin
                    stp = ANGLE_STEP;
`ifdef STICK_FINE_AIM_EN
                    if (fine_aim) stp = 1;
`endif
                    if (left_pressed && !right_pressed) m_angle = (m_angle + stp) % 360;
                    else if (right_pressed && !left_pressed) m_angle = (m_angle + 360 - stp) % 360;
                    if (space_pressed) begin m_state = S_CHARGE; m_pow = 1; end
                end
            end
            S_CHARGE: begin
                if (space_pressed) m_pow = (m_pow + 1 > POWER_MAX) ? POWER_MAX : m_pow + 1;
                else begin m_sp = m_pow; m_sa = m_angle; m_state = S_RELEASE; end
            end
            S_RELEASE: begin
                m_pow = (m_pow > RELEASE_STEP) ? m_pow - RELEASE_STEP : 0;
                if (m_pow == 0) begin m_strike = 1; m_state = S_COOL; m_cool = 0; end
            end
            S_COOL: begin
                if (!no_moving_flag) m_state = S_IDLE;
                else begin
                    m_cool++;
                    if (m_cool >= COOLDOWN_FRAMES) m_state = S_AIM;
                end
            end
            default: m_state = S_IDLE;
        endcase
    endtask

    task automatic do_tick();
        startOfFrame = 1'b1;
        model_tick();
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        obs_strike = strike;
        @(posedge clk); #1;
        obs_strike_late = strike;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Reset asserted together with a frame tick; the tick must be ignored.
    task automatic do_reset();
        reset = 1'b1;
        startOfFrame = 1'b1;
        @(posedge clk); #1;
        startOfFrame = 1'b0;
        obs_strike = strike;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        total++; if (angle !== 10'd0) begin bad++; $display("FAIL reset_angle got=%0d exp=0", angle); end
        total++; if (pull_back !== 7'd0) begin bad++; $display("FAIL reset_pull_back got=%0d exp=0", pull_back); end
        total++; if (stick_visible !== 1'b0) begin bad++; $display("FAIL reset_visible got=%0b exp=0", stick_visible); end
        total++; if (strike !== 1'b0) begin bad++; $display("FAIL reset_strike got=%0b exp=0", strike); end
        total++; if (strike_power !== 7'd0) begin bad++; $display("FAIL reset_strike_power got=%0d exp=0", strike_power); end
        total++; if (strike_angle !== 10'd0) begin bad++; $display("FAIL reset_strike_angle got=%0d exp=0", strike_angle); end
        game_state = 1'b1; no_moving_flag = 1'b1;
        do_reset();
        total++; if (stick_visible !== 1'b0) begin bad++; $display("FAIL reset_beats_tick visible got=%0b exp=0", stick_visible); end
    endtask

    task automatic test_arm();
        do_tick();
        total++; if (stick_visible !== 1'b1) begin bad++; $display("FAIL arm_visible got=%0b exp=1", stick_visible); end
        total++; if (angle !== 10'd0) begin bad++; $display("FAIL arm_angle got=%0d exp=0", angle); end
        total++; if (pull_back !== 7'd0) begin bad++; $display("FAIL arm_pull_back got=%0d exp=0", pull_back); end
    endtask

    task automatic test_rotate_wrap();
        right_pressed = 1'b1; do_tick(); right_pressed = 1'b0;
        total++; if (angle !== 10'd358) begin bad++; $display("FAIL rot_down_wrap got=%0d exp=358", angle); end
        left_pressed = 1'b1; do_tick(); left_pressed = 1'b0;
        total++; if (angle !== 10'd0) begin bad++; $display("FAIL rot_up_wrap got=%0d exp=0", angle); end
        left_pressed = 1'b1; right_pressed = 1'b1; do_tick();
        left_pressed = 1'b0; right_pressed = 1'b0;
        total++; if (angle !== 10'd0) begin bad++; $display("FAIL rot_both_keys got=%0d exp=0", angle); end
    endtask

    task automatic test_charge_strike();
        int exp_seq[5] = '{10, 7, 4, 1, 0};
        space_pressed = 1'b1; repeat (10) do_tick();
        total++; if (pull_back !== 7'd10) begin bad++; $display("FAIL charge10 got=%0d exp=10", pull_back); end
        space_pressed = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_tick();
            total++; if (pull_back !== 7'(exp_seq[i])) begin bad++; $display("FAIL release_seq[%0d] got=%0d exp=%0d", i, pull_back, exp_seq[i]); end
            total++; if (obs_strike !== (i == 4)) begin bad++; $display("FAIL strike_frame[%0d] got=%0b exp=%0b", i, obs_strike, (i == 4)); end
        end
        total++; if (obs_strike_late !== 1'b0) begin bad++; $display("FAIL strike_width got=%0b exp=0", obs_strike_late); end
        total++; if (strike_power !== 7'd10) begin bad++; $display("FAIL strike_power got=%0d exp=10", strike_power); end
        total++; if (strike_angle !== 10'd0) begin bad++; $display("FAIL strike_angle got=%0d exp=0", strike_angle); end
        for (int i = 1; i <= COOLDOWN_FRAMES; i++) begin
            do_tick();
            total++; if (stick_visible !== (i == COOLDOWN_FRAMES)) begin bad++; $display("FAIL cooldown[%0d] visible got=%0b exp=%0b", i, stick_visible, (i == COOLDOWN_FRAMES)); end
        end
    endtask

    task automatic test_saturation();
        int n;
        left_pressed = 1'b1; repeat (5) do_tick(); left_pressed = 1'b0;
        space_pressed = 1'b1; repeat (120) do_tick();
        total++; if (pull_back !== 7'd100) begin bad++; $display("FAIL sat_pull_back got=%0d exp=100", pull_back); end
        space_pressed = 1'b0;
        do_tick();
        total++; if (pull_back !== 7'd100) begin bad++; $display("FAIL sat_latch_frame got=%0d exp=100", pull_back); end
        n = 0;
        obs_strike = 1'b0;
        while (n < 50 && obs_strike !== 1'b1) begin
            do_tick();
            n++;
        end
        total++; if (n !== 34) begin bad++; $display("FAIL sat_release_frames got=%0d exp=34", n); end
        total++; if (strike_power !== 7'd100) begin bad++; $display("FAIL sat_strike_power got=%0d exp=100", strike_power); end
        total++; if (strike_angle !== 10'd10) begin bad++; $display("FAIL sat_strike_angle got=%0d exp=10", strike_angle); end
        repeat (COOLDOWN_FRAMES) do_tick();
    endtask

    task automatic test_abort();
        space_pressed = 1'b1; repeat (10) do_tick(); space_pressed = 1'b0;
        do_tick(); do_tick();
        game_state = 1'b0; do_tick();
        total++; if (obs_strike !== 1'b0) begin bad++; $display("FAIL abort_strike got=%0b exp=0", obs_strike); end
        total++; if (pull_back !== 7'd0) begin bad++; $display("FAIL abort_pull_back got=%0d exp=0", pull_back); end
        total++; if (stick_visible !== 1'b0) begin bad++; $display("FAIL abort_visible got=%0b exp=0", stick_visible); end
        total++; if (angle !== 10'd10) begin bad++; $display("FAIL abort_angle_kept got=%0d exp=10", angle); end
        game_state = 1'b1; do_tick();
        space_pressed = 1'b1; repeat (3) do_tick(); space_pressed = 1'b0;
        do_tick();
        game_state = 1'b0; do_tick();
        total++; if (obs_strike !== 1'b0) begin bad++; $display("FAIL abort_terminal_strike got=%0b exp=0", obs_strike); end
        total++; if (pull_back !== 7'd0) begin bad++; $display("FAIL abort_terminal_pull_back got=%0d exp=0", pull_back); end
        game_state = 1'b1; do_tick();
        space_pressed = 1'b1; repeat (5) do_tick(); space_pressed = 1'b0;
        do_tick(); do_tick();
        do_reset();
        total++; if (obs_strike !== 1'b0) begin bad++; $display("FAIL reset_release_strike got=%0b exp=0", obs_strike); end
        total++; if (pull_back !== 7'd0) begin bad++; $display("FAIL reset_release_pull_back got=%0d exp=0", pull_back); end
        total++; if (strike_power !== 7'd0) begin bad++; $display("FAIL reset_release_power got=%0d exp=0", strike_power); end
        do_tick();
    endtask

`ifdef STICK_FINE_AIM_EN
    task automatic test_fine_aim();
        fine_aim = 1'b1;
        right_pressed = 1'b1; do_tick(); right_pressed = 1'b0;
        total++; if (angle !== 10'd359) begin bad++; $display("FAIL fine_down got=%0d exp=359", angle); end
        left_pressed = 1'b1; do_tick(); left_pressed = 1'b0;
        total++; if (angle !== 10'd0) begin bad++; $display("FAIL fine_wrap got=%0d exp=0", angle); end
        fine_aim = 1'b0;
    endtask
`endif

    task automatic test_random();
        int run = 0;
        bit exp_vis;
        for (int i = 0; i < 600; i++) begin
            game_state     = ($urandom_range(0, 39) != 0);
            no_moving_flag = ($urandom_range(0, 19) != 0);
            left_pressed   = ($urandom_range(0, 1) == 1);
            right_pressed  = ($urandom_range(0, 1) == 1);
`ifdef STICK_FINE_AIM_EN
            fine_aim       = ($urandom_range(0, 1) == 1);
`endif
            if (run == 0) begin
                space_pressed = ~space_pressed;
                run = $urandom_range(1, 25);
            end
            run--;
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                obs_strike_late = 1'b0;
            end else
                do_tick();
            exp_vis = (m_state == S_AIM) || (m_state == S_CHARGE) || (m_state == S_RELEASE);
            total++; if (angle !== 10'(m_angle)) begin bad++; $display("FAIL rnd[%0d] angle got=%0d exp=%0d", i, angle, m_angle); end
            total++; if (pull_back !== 7'(m_pow)) begin bad++; $display("FAIL rnd[%0d] pull_back got=%0d exp=%0d", i, pull_back, m_pow); end
            total++; if (stick_visible !== exp_vis) begin bad++; $display("FAIL rnd[%0d] visible got=%0b exp=%0b", i, stick_visible, exp_vis); end
            total++; if (obs_strike !== m_strike) begin bad++; $display("FAIL rnd[%0d] strike got=%0b exp=%0b", i, obs_strike, m_strike); end
            total++; if (obs_strike_late !== 1'b0) begin bad++; $display("FAIL rnd[%0d] strike_width got=%0b exp=0", i, obs_strike_late); end
            total++; if (strike_power !== 7'(m_sp)) begin bad++; $display("FAIL rnd[%0d] strike_power got=%0d exp=%0d", i, strike_power, m_sp); end
            total++; if (strike_angle !== 10'(m_sa)) begin bad++; $display("FAIL rnd[%0d] strike_angle got=%0d exp=%0d", i, strike_angle, m_sa); end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_arm();
        test_rotate_wrap();
        test_charge_strike();
        test_saturation();
        test_abort();
`ifdef STICK_FINE_AIM_EN
        test_fine_aim();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
